// File: rtl/uvmt_cv32e40x_base_test_pkg.sv
// Shared types for the OBI slave response model: response FIFO entry and status FSM.
package uvmt_cv32e40x_base_test_pkg;

   // Widest OBI data bus the response entry can carry
   localparam int unsigned OBI_MAX_DATA_WIDTH = 64;

   // One queued response: read data (zero for writes) plus access error
   typedef struct packed {
      logic                          err;
      logic [OBI_MAX_DATA_WIDTH-1:0] rdata;
   } obi_resp_entry_t;

   localparam int unsigned OBI_RESP_ENTRY_W = $bits(obi_resp_entry_t);

   // Status FSM: IDLE when nothing is outstanding, BUSY otherwise
   typedef enum logic {
      OBI_SLV_IDLE = 1'b0,
      OBI_SLV_BUSY = 1'b1
   } obi_slv_state_e;

endpackage : uvmt_cv32e40x_base_test_pkg

// File: rtl/uvmt_cv32e40x_obi_resp_fifo.sv
// In-order response FIFO: power-of-two depth, wrapping pointers, occupancy count.
module uvmt_cv32e40x_obi_resp_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 33
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [WIDTH-1:0]       head_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rptr_q];
   assign count_o = cnt_q;

   // Guard against overflow/underflow even if the caller misbehaves
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Next pointers wrap naturally because DEPTH is a power of two
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Entry storage; contents are only meaningful while counted
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q] <= data_i;
   end

endmodule : uvmt_cv32e40x_obi_resp_fifo

// File: rtl/uvmt_cv32e40x_obi_slv_resp.sv
// OBI slave responder: grants requests, strobes backing memory, returns responses in order.
module uvmt_cv32e40x_obi_slv_resp
   import uvmt_cv32e40x_base_test_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    gnt_o,
   output logic                    gntpar_o,
   output logic                    rvalid_o,
   output logic                    rvalidpar_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o,
   input  logic                    gnt_stall_i,
   input  logic                    rvalid_stall_i,
   output logic                    mem_req_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_err_i,
   output logic                    busy_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   obi_resp_entry_t push_entry;
   obi_resp_entry_t head_entry;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic            accept;
   logic            pop;
   obi_slv_state_e  state_q, state_d;

   // Grant uses start-of-cycle fullness, so a same-cycle pop never frees a slot early
   assign gnt_o    = rst_ni && req_i && !fifo_full && !gnt_stall_i;
   assign gntpar_o = !gnt_o;
   assign accept   = req_i && gnt_o;

   // Backing memory sees the accepted request in the same cycle
   assign mem_req_o   = accept;
   assign mem_addr_o  = addr_i;
   assign mem_we_o    = we_i;
   assign mem_be_o    = be_i;
   assign mem_wdata_o = wdata_i;

   // Writes return zero data; the error flag is captured for both directions
   assign push_entry.err   = mem_err_i;
   assign push_entry.rdata = we_i ? '0 : OBI_MAX_DATA_WIDTH'(mem_rdata_i);

   // No rready on this OBI flavour: every presented response is consumed
   assign rvalid_o    = rst_ni && !fifo_empty && !rvalid_stall_i;
   assign rvalidpar_o = !rvalid_o;
   assign pop         = rvalid_o;
   assign rdata_o     = rvalid_o ? DATA_WIDTH'(head_entry.rdata) : '0;
   assign err_o       = rvalid_o && head_entry.err;

   // Pad bits above DATA_WIDTH are never presented
   if (DATA_WIDTH < OBI_MAX_DATA_WIDTH) begin : g_pad
      logic unused_pad_c;
      assign unused_pad_c = |head_entry.rdata[OBI_MAX_DATA_WIDTH-1:DATA_WIDTH];
   end

   uvmt_cv32e40x_obi_resp_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (OBI_RESP_ENTRY_W)
   ) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (accept),
      .pop_i   (pop),
      .data_i  (push_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head_entry),
      .count_o (fifo_count)
   );

   // Status next-state: leave IDLE on any push, return when the last entry drains
   always_comb begin
      state_d = state_q;
      case (state_q)
         OBI_SLV_IDLE: if (accept) state_d = OBI_SLV_BUSY;
         OBI_SLV_BUSY: if (pop && !accept && (fifo_count == CNT_W'(1))) state_d = OBI_SLV_IDLE;
         default:      state_d = OBI_SLV_IDLE;
      endcase
   end

   // Status state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= OBI_SLV_IDLE;
      else         state_q <= state_d;
   end

   assign busy_o = (state_q == OBI_SLV_BUSY);

endmodule : uvmt_cv32e40x_obi_slv_resp

// File: tb/tb_uvmt_cv32e40x_obi_slv_resp.sv
// Self-checking bench: directed OBI scenarios plus random traffic against a queue model.
module tb_uvmt_cv32e40x_obi_slv_resp;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          req_i, we_i, gnt_stall_i, rvalid_stall_i, mem_err_i;
   logic [AW-1:0] addr_i;
   logic [3:0]    be_i;
   logic [DW-1:0] wdata_i, mem_rdata_i;
   logic          gnt_o, gntpar_o, rvalid_o, rvalidpar_o, err_o, mem_req_o, mem_we_o, busy_o;
   logic [DW-1:0] rdata_o, mem_wdata_o;
   logic [AW-1:0] mem_addr_o;
   logic [3:0]    mem_be_o;

   int n_tests = 0;
   int n_fail  = 0;
   int n_gnt   = 0;
   logic last_gnt;
   logic [32:0] exp_q[$];   // {err, rdata} in acceptance order

   always #5 clk_i = ~clk_i;

   uvmt_cv32e40x_obi_slv_resp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
      .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .gntpar_o(gntpar_o),
      .rvalid_o(rvalid_o), .rvalidpar_o(rvalidpar_o), .rdata_o(rdata_o), .err_o(err_o),
      .gnt_stall_i(gnt_stall_i), .rvalid_stall_i(rvalid_stall_i), .mem_req_o(mem_req_o),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .busy_o(busy_o)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Outputs expected while reset is held, whatever was outstanding
   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_gnt"},       gnt_o,       0);
      check_val({tag, "_gntpar"},    gntpar_o,    1);
      check_val({tag, "_rvalid"},    rvalid_o,    0);
      check_val({tag, "_rvalidpar"}, rvalidpar_o, 1);
      check_val({tag, "_rdata"},     rdata_o,     0);
      check_val({tag, "_err"},       err_o,       0);
      check_val({tag, "_memreq"},    mem_req_o,   0);
      check_val({tag, "_busy"},      busy_o,      0);
   endtask

   // One clock: drive (just after posedge), check mid-cycle against the model, advance model
   task automatic step(input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, input logic [31:0] mrd,
                       input logic merr, input logic gs, input logic rs);
      logic exp_gnt, exp_rv;
      req_i = req; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
      mem_rdata_i = mrd; mem_err_i = merr; gnt_stall_i = gs; rvalid_stall_i = rs;
      #4;
      exp_gnt = req && (exp_q.size() < DEPTH) && !gs;
      exp_rv  = (exp_q.size() != 0) && !rs;
      check_val("gnt",       gnt_o,       exp_gnt);
      check_val("gntpar",    gntpar_o,    !exp_gnt);
      check_val("mem_req",   mem_req_o,   exp_gnt);
      check_val("rvalid",    rvalid_o,    exp_rv);
      check_val("rvalidpar", rvalidpar_o, !exp_rv);
      check_val("busy",      busy_o,      exp_q.size() != 0);
      if (exp_rv) begin
         check_val("rdata", rdata_o, exp_q[0][31:0]);
         check_val("err",   err_o,   exp_q[0][32]);
      end else begin
         check_val("rdata_idle", rdata_o, 0);
         check_val("err_idle",   err_o,   0);
      end
      if (exp_gnt) begin
         check_val("mem_addr",  mem_addr_o,  addr);
         check_val("mem_we",    mem_we_o,    we);
         check_val("mem_be",    mem_be_o,    be);
         check_val("mem_wdata", mem_wdata_o, wd);
         n_gnt++;
      end
      last_gnt = exp_gnt;
      if (exp_rv) void'(exp_q.pop_front());
      if (exp_gnt) exp_q.push_back({merr, we ? 32'h0 : mrd});
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n, input logic rs);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rs);
   endtask

   initial begin
      int g;
      bit got;
      rst_ni = 1'b0; req_i = 1'b1; we_i = 0; addr_i = '0; be_i = '0; wdata_i = '0;
      mem_rdata_i = '0; mem_err_i = 0; gnt_stall_i = 0; rvalid_stall_i = 0;
      #2;
      check_reset_outputs("rst");
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      idle(1, 0);

      // Single read, no stalls
      step(1, 0, 32'h80, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0);
      check_val("rd80_gnt", last_gnt, 1);
      check_val("rd80_model_head", exp_q[0], {1'b0, 32'hDEADBEEF});
      idle(2, 0);

      // Five reads with responses stalled: only DEPTH grants
      g = n_gnt;
      for (int i = 0; i < 5; i++) step(1, 0, 32'h100 + 4*i, 4'hF, 0, 32'hA000 + i, 0, 0, 1);
      check_val("stall_grants", n_gnt - g, DEPTH);
      // Release: hold the fifth request until granted (bounded)
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         step(1, 0, 32'h110, 4'hF, 0, 32'hA004, 0, 0, 0);
         got = last_gnt;
      end
      check_val("fifth_granted", got, 1);
      idle(6, 0);

      // Write returns zero data
      step(1, 1, 32'h40, 4'hF, 32'h12345678, 32'hFFFFFFFF, 0, 0, 0);
      check_val("wr_mem_we", last_gnt, 1);
      idle(2, 0);

      // Error only on the second of three reads
      for (int i = 0; i < 3; i++) step(1, 0, 32'h200 + 4*i, 4'hF, 0, 32'hB0 + i, i == 1, 0, 0);
      idle(2, 0);

      // Full with simultaneous pop: blocked this cycle, granted next
      for (int i = 0; i < 4; i++) step(1, 0, 32'h300, 4'hF, 0, 32'hC0 + i, 0, 0, 1);
      step(1, 0, 32'h310, 4'hF, 0, 32'hC4, 0, 0, 0);
      check_val("full_pop_gnt", last_gnt, 0);
      step(1, 0, 32'h310, 4'hF, 0, 32'hC4, 0, 0, 0);
      check_val("after_full_gnt", last_gnt, 1);
      idle(6, 0);

      // Grant back-pressure holds state
      step(1, 0, 32'h400, 4'hF, 0, 32'h55, 0, 1, 0);
      check_val("gstall_gnt", last_gnt, 0);
      step(1, 0, 32'h400, 4'hF, 0, 32'h55, 0, 0, 0);
      idle(2, 0);

      // Reset with three entries outstanding discards them
      for (int i = 0; i < 3; i++) step(1, 0, 32'h500, 4'hF, 0, 32'hD0 + i, 0, 0, 1);
      rst_ni = 1'b0; req_i = 1'b1; rvalid_stall_i = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      idle(3, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 9) < 7, 1'($urandom), $urandom, 4'($urandom), $urandom,
              $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 4);
      idle(8, 0);
      check_val("drained", busy_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uvmt_cv32e40x_obi_slv_resp
